// File: rtl/input_mem_reader.sv
// rtl/input_mem_reader.sv - burst read sequencer for the 64x8 input memory
// Issues reads on credit so that a small skid FIFO absorbs memory latency and stream backpressure.
module input_mem_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int FIFO_D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_ptr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_data_ptr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int IW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_beat_cnt;
  logic              r_inflight;
  logic              r_done;
  logic [DATA_W-1:0] r_fifo [FIFO_D];
  logic [IW-1:0]     r_wr_idx;
  logic [IW-1:0]     r_rd_idx;
  logic [CW-1:0]     r_count;

  logic          w_pop;
  logic          w_issue;
  logic          w_last;
  logic [CW:0]   w_credit;
  logic [IW-1:0] w_wr_nxt;
  logic [IW-1:0] w_rd_nxt;

  assign out_valid   = (r_count != '0);
  assign out_data    = r_fifo[r_rd_idx];
  assign w_last      = out_valid && (r_beat_cnt == r_len - 1'b1);
  assign out_last    = w_last;
  assign w_pop       = out_valid && out_ready;
  assign rd_data_ptr = r_rd_ptr;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

  // Occupancy the FIFO will reach once the outstanding read lands, net of this cycle's pop.
  assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue  = (r_state == S_READ) && (r_remaining != '0) &&
                    (w_credit < (CW + 1)'(FIFO_D));

  assign w_wr_nxt = (r_wr_idx == IW'(FIFO_D - 1)) ? '0 : r_wr_idx + 1'b1;
  assign w_rd_nxt = (r_rd_idx == IW'(FIFO_D - 1)) ? '0 : r_rd_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_D; i++) r_fifo[i] <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      r_count    <= r_count + CW'(r_inflight) - CW'(w_pop);
      if (r_inflight) begin
        r_fifo[r_wr_idx] <= mem_data;
        r_wr_idx         <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd_idx   <= w_rd_nxt;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= S_READ;
              r_rd_ptr    <= base_ptr;
              r_remaining <= length;
              r_len       <= length;
              r_beat_cnt  <= '0;
            end
          end
        end
        S_READ: begin
          if ((r_remaining == '0) || (w_issue && (r_remaining == 1)))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_mem_reader.sv
// tb/tb_input_mem_reader.sv - directed self-checking bench for input_mem_reader
// Bench owns a 64x8 registered-read memory model; expected bytes come from its contents.
module tb_input_mem_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] base_ptr;
  logic [6:0] length;
  logic [5:0] rd_data_ptr;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [64];
  int checks;
  int errors;

  input_mem_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_ptr(base_ptr), .length(length),
    .rd_data_ptr(rd_data_ptr), .mem_data(mem_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[rd_data_ptr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drains one burst; mode 0 holds ready high, mode 1 drives ready 1,0,0,1,0,0...
  task automatic collect(input logic [5:0] base, input int len, input int mode);
    int k;
    int cyc;
    logic [5:0] a;
    k = 0;
    cyc = 0;
    while (k < len && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (out_valid) begin
        a = base + 6'(k);
        chk(out_ready ? "beat_data" : "held_data", {24'd0, out_data}, {24'd0, mem[a]});
        chk(out_ready ? "beat_last" : "held_last", {31'd0, out_last}, {31'd0, k == len - 1});
        if (out_ready) k++;
      end
      tick();
      cyc++;
    end
    chk("beat_count", k, len);
    chk("done_after_last", {31'd0, done}, 32'd1);
    chk("busy_after_last", {31'd0, busy}, 32'd0);
    chk("valid_after_last", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 11);
    rst = 1'b1;
    start = 1'b0;
    base_ptr = '0;
    length = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_ptr", {26'd0, rd_data_ptr}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: base 0, length 4, latency and cycle-exact beats
    start = 1'b1; base_ptr = 6'd0; length = 7'd4;
    tick();
    start = 1'b0;
    chk("t1_ptr_e0", {26'd0, rd_data_ptr}, 32'd0);
    chk("t1_busy_e0", {31'd0, busy}, 32'd1);
    chk("t1_valid_e0", {31'd0, out_valid}, 32'd0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("t1_ptr", {26'd0, rd_data_ptr}, (e <= 4) ? e : 4);
      chk("t1_valid", {31'd0, out_valid}, {31'd0, (e >= 2 && e <= 5)});
      if (e >= 2 && e <= 5) begin
        chk("t1_data", {24'd0, out_data}, {24'd0, mem[e - 2]});
        chk("t1_last", {31'd0, out_last}, {31'd0, e == 5});
      end
      chk("t1_done", {31'd0, done}, {31'd0, e == 6});
      chk("t1_busy", {31'd0, busy}, {31'd0, e < 6});
    end
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // 2: address wrap 62,63,0,1
    start = 1'b1; base_ptr = 6'd62; length = 7'd4;
    tick();
    start = 1'b0;
    collect(6'd62, 4, 0);
    chk("t2_ptr_end", {26'd0, rd_data_ptr}, 32'd2);

    // 3: backpressure pattern
    start = 1'b1; base_ptr = 6'd20; length = 7'd8;
    tick();
    start = 1'b0;
    collect(6'd20, 8, 1);

    // 4: zero length
    start = 1'b1; base_ptr = 6'd9; length = 7'd0;
    tick();
    start = 1'b0;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t4_done_pulse", {31'd0, done}, 32'd0);
    chk("t4_valid2", {31'd0, out_valid}, 32'd0);

    // 5: second start mid-burst is ignored
    start = 1'b1; base_ptr = 6'd10; length = 7'd6;
    tick();
    base_ptr = 6'd40; length = 7'd3;
    tick();
    start = 1'b0;
    collect(6'd10, 6, 0);

    // full-depth burst touches every address once
    start = 1'b1; base_ptr = 6'd7; length = 7'd64;
    tick();
    start = 1'b0;
    collect(6'd7, 64, 0);
    chk("t64_ptr_end", {26'd0, rd_data_ptr}, 32'd7);

    // 6: reset mid-burst after two beats
    start = 1'b1; base_ptr = 6'd30; length = 7'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_beat1", {24'd0, out_data}, {24'd0, mem[30]});
    tick();
    chk("t6_beat2", {24'd0, out_data}, {24'd0, mem[31]});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_ptr", {26'd0, rd_data_ptr}, 32'd0);
    chk("t6_data", {24'd0, out_data}, 32'd0);
    chk("t6_last", {31'd0, out_last}, 32'd0);
    tick();
    chk("t6_no_done", {31'd0, done}, 32'd0);
    chk("t6_still_empty", {31'd0, out_valid}, 32'd0);
    start = 1'b1; base_ptr = 6'd5; length = 7'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_new_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_new_data", {24'd0, out_data}, {24'd0, mem[5]});
    chk("t6_new_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("t6_new_done", {31'd0, done}, 32'd1);
    chk("t6_new_valid_end", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
